// File: rtl/bft_pi_arbiter_pipe.sv
// Pipelined deflection-routing arbiter for a BFT switch node (pi or t mode).
// Produces output-mux selects, per-input deflection flags and a saturating deflection count.
module bft_pi_arbiter_pipe #(
  parameter bit         IS_PI      = 1'b1,
  parameter int         PIPE_DEPTH = 5,
  parameter bit         RAND_EN    = 1'b1,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         DCNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [1:0]        d_l,
  input  logic [1:0]        d_r,
  input  logic [1:0]        d_ul,
  input  logic [1:0]        d_ur,
  output logic [1:0]        sel_l,
  output logic [1:0]        sel_r,
  output logic [1:0]        sel_ul,
  output logic [1:0]        sel_ur,
  output logic [3:0]        deflect,
  output logic              rand_gen,
  input  logic              dcnt_clr,
  output logic [DCNT_W-1:0] dcnt
);

  localparam logic [1:0] D_VOID  = 2'b00;
  localparam logic [1:0] D_LEFT  = 2'b01;
  localparam logic [1:0] D_RIGHT = 2'b10;
  localparam logic [1:0] D_UP    = 2'b11;

  localparam logic [1:0] S_LEFT  = 2'b01;
  localparam logic [1:0] S_RIGHT = 2'b10;
  localparam logic [1:0] S_UPL   = 2'b11;
  localparam logic [1:0] S_UPR   = 2'b00;

  localparam logic [1:0] O_L  = 2'd0;
  localparam logic [1:0] O_R  = 2'd1;
  localparam logic [1:0] O_U1 = 2'd2;
  localparam logic [1:0] O_U2 = 2'd3;

  typedef struct packed {
    logic [3:0]      taken;
    logic [3:0]      done;
    logic [3:0][1:0] asg;
  } arb_t;

  // Preference list, o0 tried first.
  function automatic logic [7:0] ord(input logic [1:0] o0, input logic [1:0] o1,
                                     input logic [1:0] o2, input logic [1:0] o3);
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [2:0] first_free(input logic [3:0] taken, input logic [7:0] order);
    logic [2:0] res;
    res = 3'b000;
    res = taken[order[7:6]] ? res : {1'b1, order[7:6]};
    res = taken[order[5:4]] ? res : {1'b1, order[5:4]};
    res = taken[order[3:2]] ? res : {1'b1, order[3:2]};
    res = taken[order[1:0]] ? res : {1'b1, order[1:0]};
    return res;
  endfunction

  function automatic arb_t claim(input arb_t st, input logic [1:0] src,
                                 input logic [7:0] order, input logic en);
    arb_t       res;
    logic [2:0] pick;
    res  = st;
    pick = first_free(st.taken, order);
    if (en && pick[2]) begin
      res.taken[pick[1:0]] = 1'b1;
      res.done[src]        = 1'b1;
      res.asg[src]         = pick[1:0];
    end else begin
      res = st;
    end
    return res;
  endfunction

  function automatic logic [1:0] src_code(input logic [1:0] src);
    case (src)
      2'd0:    return S_LEFT;
      2'd1:    return S_RIGHT;
      2'd2:    return S_UPL;
      default: return S_UPR;
    endcase
  endfunction

  function automatic logic [1:0] dir_of(input logic [1:0] outp);
    case (outp)
      O_L:     return D_LEFT;
      O_R:     return D_RIGHT;
      default: return D_UP;
    endcase
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [7:0]        vec_s;
  logic [7:0]        arb_in_s;
  logic [1:0]        din_s [4];
  arb_t              st_s;
  logic              ul_dn_s, ur_dn_s, ul_won_s;
  logic [1:0]        ul_side_s, ur_side_s;
  logic [7:0]        ur_order_s;
  logic [1:0]        fill_s;
  logic [1:0]        sel_s [4];
  logic [3:0]        defl_s;
  logic              rg_s;
  logic              swap_s;
  logic [DCNT_W+2:0] dsum_s;

  logic [1:0]        sel_l_r, sel_r_r, sel_ul_r, sel_ur_r;
  logic [3:0]        deflect_r;
  logic              rand_gen_r;
  logic [7:0]        lfsr_r;
  logic [DCNT_W-1:0] dcnt_r;

  // A t switch never sees a packet on ur.
  assign vec_s = {d_l, d_r, d_ul, (IS_PI ? d_ur : D_VOID)};

  generate
    if (PIPE_DEPTH <= 1) begin : g_nopipe
      assign arb_in_s = vec_s;
    end else begin : g_pipe
      logic [7:0] pipe_r [PIPE_DEPTH-1];
      // Request-vector delay line, VOID after reset
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < PIPE_DEPTH-1; k++) pipe_r[k] <= 8'h00;
        end else if (ce) begin
          pipe_r[0] <= vec_s;
          for (int k = 1; k < PIPE_DEPTH-1; k++) pipe_r[k] <= pipe_r[k-1];
        end
      end
      assign arb_in_s = pipe_r[PIPE_DEPTH-2];
    end
  endgenerate

  // Priority arbitration: turnback, downlinks, side links, uplinks, then void fill
  always_comb begin
    din_s[0] = arb_in_s[7:6];
    din_s[1] = arb_in_s[5:4];
    din_s[2] = arb_in_s[3:2];
    din_s[3] = arb_in_s[1:0];
    st_s       = '0;
    st_s.taken = IS_PI ? 4'b0000 : 4'b1000;

    st_s = claim(st_s, 2'd0, ord(O_L,  O_L,  O_L,  O_L),  din_s[0] == D_LEFT);
    st_s = claim(st_s, 2'd1, ord(O_R,  O_R,  O_R,  O_R),  din_s[1] == D_RIGHT);
    st_s = claim(st_s, 2'd2, ord(O_U1, O_U1, O_U1, O_U1), din_s[2] == D_UP);
    st_s = claim(st_s, 2'd3, ord(O_U2, O_U2, O_U2, O_U2), din_s[3] == D_UP);

    ul_dn_s   = (din_s[2] == D_LEFT) || (din_s[2] == D_RIGHT);
    ur_dn_s   = (din_s[3] == D_LEFT) || (din_s[3] == D_RIGHT);
    ul_side_s = (din_s[2] == D_LEFT) ? O_L : O_R;
    ur_side_s = (din_s[3] == D_LEFT) ? O_L : O_R;
    st_s      = claim(st_s, 2'd2, ord(ul_side_s, O_U1, O_U1, O_U1), ul_dn_s);
    ul_won_s  = ul_dn_s && (st_s.asg[2] == ul_side_s);
    // ur loses a shared side to ul and is pushed onto the u1 port ul left free
    ur_order_s = (ul_won_s && (din_s[3] == din_s[2])) ? ord(O_U1, O_U1, O_U1, O_U1)
                                                      : ord(ur_side_s, O_U2, O_U2, O_U2);
    st_s = claim(st_s, 2'd3, ur_order_s, ur_dn_s);

    st_s = claim(st_s, 2'd0, ord(O_R,  O_L,  O_U1, O_U2), din_s[0] == D_RIGHT);
    st_s = claim(st_s, 2'd1, ord(O_L,  O_R,  O_U1, O_U2), din_s[1] == D_LEFT);
    st_s = claim(st_s, 2'd0, ord(O_U1, O_U2, O_L,  O_R),  din_s[0] == D_UP);
    st_s = claim(st_s, 2'd1, ord(O_U1, O_U2, O_R,  O_L),  din_s[1] == D_UP);

    fill_s = S_LEFT;
    for (int i = 0; i < 4; i++) begin
      fill_s = (din_s[i] == D_VOID) ? src_code(2'(i)) : fill_s;
    end
    for (int o = 0; o < 4; o++) begin
      sel_s[o] = st_s.taken[o] ? S_LEFT : fill_s;
    end

    defl_s = 4'b0000;
    rg_s   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (st_s.done[i]) begin
        sel_s[st_s.asg[i]] = src_code(2'(i));
        defl_s[3-i]        = (dir_of(st_s.asg[i]) != din_s[i]);
        rg_s               = rg_s | st_s.asg[i][1];
      end else begin
        defl_s[3-i] = 1'b0;
      end
    end
  end

  assign swap_s = RAND_EN && IS_PI && !lfsr_r[0];
  assign dsum_s = {3'b000, dcnt_r} + {{DCNT_W{1'b0}}, popcount4(defl_s)};

  // Output register with the LFSR-controlled up-port swap
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_l_r    <= S_LEFT;
      sel_r_r    <= S_LEFT;
      sel_ul_r   <= S_LEFT;
      sel_ur_r   <= S_LEFT;
      deflect_r  <= 4'b0000;
      rand_gen_r <= 1'b0;
    end else if (ce) begin
      sel_l_r    <= sel_s[O_L];
      sel_r_r    <= sel_s[O_R];
      sel_ul_r   <= swap_s ? sel_s[O_U2] : sel_s[O_U1];
      sel_ur_r   <= swap_s ? sel_s[O_U1] : sel_s[O_U2];
      deflect_r  <= defl_s;
      rand_gen_r <= rg_s;
    end
  end

  // Swap LFSR, stepped only after a result that used an up port
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (ce && rand_gen_r) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Saturating deflection counter; clear works even while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_r <= {DCNT_W{1'b0}};
    end else if (dcnt_clr) begin
      dcnt_r <= {DCNT_W{1'b0}};
    end else if (ce) begin
      dcnt_r <= (|dsum_s[DCNT_W+2:DCNT_W]) ? {DCNT_W{1'b1}} : dsum_s[DCNT_W-1:0];
    end
  end

  assign sel_l    = sel_l_r;
  assign sel_r    = sel_r_r;
  assign sel_ul   = sel_ul_r;
  assign sel_ur   = sel_ur_r;
  assign deflect  = deflect_r;
  assign rand_gen = rand_gen_r;
  assign dcnt     = dcnt_r;

endmodule

// File: tb/tb_bft_pi_arbiter_pipe.sv
// Directed bench: four arbiter configurations share one stimulus stream;
// expected values are hand-derived, with a small LFSR model for the swap check.
module tb_bft_pi_arbiter_pipe;

  localparam logic [1:0] VD = 2'b00;
  localparam logic [1:0] LF = 2'b01;
  localparam logic [1:0] RT = 2'b10;
  localparam logic [1:0] UP = 2'b11;

  logic clk, reset, ce, dcnt_clr;
  logic [1:0] d_l, d_r, d_ul, d_ur;

  logic [1:0]  sl [4];
  logic [1:0]  sr [4];
  logic [1:0]  sul [4];
  logic [1:0]  sur [4];
  logic [3:0]  df [4];
  logic        rg [4];
  logic [15:0] dc0, dc1, dc2;
  logic [1:0]  dc3;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_lfsr;
  logic       m_rg, cap, swp;

  // u0: reference pi config, u1: single-stage, u2: random swap, u3: t mode with 2-bit counter
  bft_pi_arbiter_pipe #(.IS_PI(1'b1), .PIPE_DEPTH(5), .RAND_EN(1'b0), .DCNT_W(16)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .d_l(d_l), .d_r(d_r), .d_ul(d_ul), .d_ur(d_ur),
    .sel_l(sl[0]), .sel_r(sr[0]), .sel_ul(sul[0]), .sel_ur(sur[0]), .deflect(df[0]),
    .rand_gen(rg[0]), .dcnt_clr(dcnt_clr), .dcnt(dc0));
  bft_pi_arbiter_pipe #(.IS_PI(1'b1), .PIPE_DEPTH(1), .RAND_EN(1'b0), .DCNT_W(16)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .d_l(d_l), .d_r(d_r), .d_ul(d_ul), .d_ur(d_ur),
    .sel_l(sl[1]), .sel_r(sr[1]), .sel_ul(sul[1]), .sel_ur(sur[1]), .deflect(df[1]),
    .rand_gen(rg[1]), .dcnt_clr(dcnt_clr), .dcnt(dc1));
  bft_pi_arbiter_pipe #(.IS_PI(1'b1), .PIPE_DEPTH(5), .RAND_EN(1'b1), .DCNT_W(16)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .d_l(d_l), .d_r(d_r), .d_ul(d_ul), .d_ur(d_ur),
    .sel_l(sl[2]), .sel_r(sr[2]), .sel_ul(sul[2]), .sel_ur(sur[2]), .deflect(df[2]),
    .rand_gen(rg[2]), .dcnt_clr(dcnt_clr), .dcnt(dc2));
  bft_pi_arbiter_pipe #(.IS_PI(1'b0), .PIPE_DEPTH(2), .RAND_EN(1'b1), .DCNT_W(2)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .d_l(d_l), .d_r(d_r), .d_ul(d_ul), .d_ur(d_ur),
    .sel_l(sl[3]), .sel_r(sr[3]), .sel_ul(sul[3]), .sel_ur(sur[3]), .deflect(df[3]),
    .rand_gen(rg[3]), .dcnt_clr(dcnt_clr), .dcnt(dc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setd(input logic [1:0] l, input logic [1:0] r,
                      input logic [1:0] ul, input logic [1:0] ur);
    d_l = l; d_r = r; d_ul = ul; d_ur = ur;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  initial begin
    // Reset with ce low: reset must still win
    reset = 1'b1; ce = 1'b0; dcnt_clr = 1'b0;
    setd(UP, LF, RT, UP);
    tick(3);
    chk("rst_sel_l",  16'(sl[0]),  16'h1);
    chk("rst_sel_r",  16'(sr[0]),  16'h1);
    chk("rst_sel_ul", 16'(sul[0]), 16'h1);
    chk("rst_sel_ur", 16'(sur[0]), 16'h1);
    chk("rst_defl",   16'(df[0]),  16'h0);
    chk("rst_rg",     16'(rg[0]),  16'h0);
    chk("rst_dcnt",   dc0,         16'h0);
    chk("rst_t_dcnt", 16'(dc3),    16'h0);

    // All VOID after release: ur-void fills every output
    reset = 1'b0; ce = 1'b1;
    setd(VD, VD, VD, VD);
    tick(1);
    chk("void_sel_l",  16'(sl[0]),  16'h0);
    chk("void_sel_r",  16'(sr[0]),  16'h0);
    chk("void_sel_ul", 16'(sul[0]), 16'h0);
    chk("void_sel_ur", 16'(sur[0]), 16'h0);
    chk("void_t_ur",   16'(sur[3]), 16'h1);

    // Full turnback with LFSR swap on u2
    setd(LF, RT, UP, UP);
    m_lfsr = 8'hA5; m_rg = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick(1);
      cap = (n >= 5);
      swp = ~m_lfsr[0];
      if (m_rg) m_lfsr = lfsr_next(m_lfsr);
      m_rg = cap;
      chk("swap_ul", 16'(sul[2]), cap ? (swp ? 16'h0 : 16'h3) : 16'h0);
      chk("swap_ur", 16'(sur[2]), cap ? (swp ? 16'h3 : 16'h0) : 16'h0);
      chk("swap_rg", 16'(rg[2]),  16'(cap));
    end
    chk("tb_sel_l",  16'(sl[0]),  16'h1);
    chk("tb_sel_r",  16'(sr[0]),  16'h2);
    chk("tb_sel_ul", 16'(sul[0]), 16'h3);
    chk("tb_sel_ur", 16'(sur[0]), 16'h0);
    chk("tb_defl",   16'(df[0]),  16'h0);

    // Crossing: exact 5-edge latency on u0, 1-edge on u1
    setd(RT, LF, VD, VD);
    tick(4);
    chk("cross_early_l", 16'(sl[0]), 16'h1);
    chk("cross_d1_l",    16'(sl[1]), 16'h2);
    tick(1);
    chk("cross_sel_l",  16'(sl[0]),  16'h2);
    chk("cross_sel_r",  16'(sr[0]),  16'h1);
    chk("cross_sel_ul", 16'(sul[0]), 16'h0);
    chk("cross_sel_ur", 16'(sur[0]), 16'h0);
    chk("cross_defl",   16'(df[0]),  16'h0);
    chk("cross_rg",     16'(rg[0]),  16'h0);

    // Downlink contention: ul wins l, ur deflected to u1
    setd(VD, VD, LF, LF);
    tick(5);
    chk("cont_sel_l",  16'(sl[0]),  16'h3);
    chk("cont_sel_r",  16'(sr[0]),  16'h2);
    chk("cont_sel_ul", 16'(sul[0]), 16'h0);
    chk("cont_sel_ur", 16'(sur[0]), 16'h2);
    chk("cont_defl",   16'(df[0]),  16'h1);
    chk("cont_rg",     16'(rg[0]),  16'h1);
    chk("cont_dcnt1",  dc0,         16'h1);
    tick(1);
    chk("cont_dcnt2",  dc0,         16'h2);
    chk("cont_d1_dcnt", dc1,        16'h6);

    // Stall: settle on crossing with counters cleared, then stall mid-stream
    setd(RT, LF, VD, VD);
    dcnt_clr = 1'b1;
    tick(6);
    chk("pre_stall_dcnt", dc0,        16'h0);
    chk("pre_stall_l",    16'(sl[0]), 16'h2);
    dcnt_clr = 1'b0;
    setd(VD, VD, LF, LF);
    tick(2);
    ce = 1'b0;
    setd(LF, RT, UP, UP);
    for (int s = 0; s < 3; s++) begin
      tick(1);
      chk("stall_d5_l",    16'(sl[0]), 16'h2);
      chk("stall_d5_dcnt", dc0,        16'h0);
      chk("stall_d1_l",    16'(sl[1]), 16'h3);
      chk("stall_d1_dcnt", dc1,        16'h2);
    end
    setd(VD, VD, LF, LF);
    ce = 1'b1;
    tick(2);
    chk("resume_early_l", 16'(sl[0]), 16'h2);
    tick(1);
    chk("resume_l",    16'(sl[0]),  16'h3);
    chk("resume_ur",   16'(sur[0]), 16'h2);
    chk("resume_defl", 16'(df[0]),  16'h1);
    chk("resume_dcnt", dc0,         16'h1);
    chk("resume_d1_dcnt", dc1,      16'h5);

    // t mode: ur ignored, u2 never assigned
    dcnt_clr = 1'b1;
    setd(UP, VD, VD, UP);
    tick(5);
    chk("t_sel_l",  16'(sl[3]),  16'h0);
    chk("t_sel_r",  16'(sr[3]),  16'h0);
    chk("t_sel_ul", 16'(sul[3]), 16'h1);
    chk("t_sel_ur", 16'(sur[3]), 16'h1);
    chk("t_defl",   16'(df[3]),  16'h0);
    chk("t_rg",     16'(rg[3]),  16'h1);

    // t mode: ul finds l taken and turns back, one deflection per result
    dcnt_clr = 1'b0;
    setd(LF, VD, LF, VD);
    tick(7);
    chk("tdef_sel_l",  16'(sl[3]),  16'h1);
    chk("tdef_sel_ul", 16'(sul[3]), 16'h3);
    chk("tdef_sel_r",  16'(sr[3]),  16'h0);
    chk("tdef_sel_ur", 16'(sur[3]), 16'h1);
    chk("tdef_defl",   16'(df[3]),  16'h2);
    chk("tdef_sat",    16'(dc3),    16'h3);
    ce = 1'b0; dcnt_clr = 1'b1;
    tick(1);
    chk("clr_stalled", 16'(dc3), 16'h0);
    ce = 1'b1; dcnt_clr = 1'b0;
    tick(1);
    chk("cnt_after_clr", 16'(dc3), 16'h1);
    dcnt_clr = 1'b1;
    tick(1);
    chk("clr_priority", 16'(dc3), 16'h0);
    dcnt_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
